// File: rtl/next_pc_unit.sv
// Fetch PC register and next-PC selection for the single-cycle MIPS datapath.
// A one-entry redirect buffer holds a control transfer requested while stalled.
module next_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic [2:0]  branch_type,
  input  logic [31:0] branch_off,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        jump,
  input  logic [25:0] instr_index,
  input  logic        jr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        taken,
  output logic        pending_valid,
  output logic        misaligned
);

  localparam logic [2:0] BR_BEQ  = 3'b001;
  localparam logic [2:0] BR_BNE  = 3'b010;
  localparam logic [2:0] BR_BLEZ = 3'b011;
  localparam logic [2:0] BR_BGTZ = 3'b100;
  localparam logic [2:0] BR_BLTZ = 3'b101;
  localparam logic [2:0] BR_BGEZ = 3'b110;

  logic [31:0] pending_target;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] redirect_target;
  logic        branch_cond;
  logic        rs_neg;
  logic        rs_zero;

  assign pc_plus4      = pc + 32'd4;
  assign branch_target = pc_plus4 + branch_off;
  assign jump_target   = {pc_plus4[31:28], instr_index, 2'b00};
  assign misaligned    = |pc[1:0];

  // Sign-bit and zero tests are the signed compares against zero.
  assign rs_neg  = rs_data[31];
  assign rs_zero = (rs_data == 32'd0);

  always_comb begin
    branch_cond = 1'b0;
    case (branch_type)
      BR_BEQ:  branch_cond = (rs_data == rt_data);
      BR_BNE:  branch_cond = (rs_data != rt_data);
      BR_BLEZ: branch_cond = rs_neg | rs_zero;
      BR_BGTZ: branch_cond = ~rs_neg & ~rs_zero;
      BR_BLTZ: branch_cond = rs_neg;
      BR_BGEZ: branch_cond = ~rs_neg;
      default: branch_cond = 1'b0;
    endcase
  end

  assign taken = jr | jump | branch_cond;

  always_comb begin
    redirect_target = branch_target;
    if (jr)
      redirect_target = rs_data;
    else if (jump)
      redirect_target = jump_target;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc             <= RESET_PC;
      pending_valid  <= 1'b0;
      pending_target <= 32'd0;
    end else if (!stall) begin
      if (pending_valid) begin
        pc            <= pending_target;
        pending_valid <= 1'b0;
      end else if (taken) begin
        pc <= redirect_target;
      end else begin
        pc <= pc_plus4;
      end
    end else if (!pending_valid && taken) begin
      // First request during a stall wins; later ones are dropped.
      pending_target <= redirect_target;
      pending_valid  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_next_pc_unit.sv
// Randomized and directed bench for next_pc_unit with a queue-based scoreboard
// fed by a behavioural PC model.
module tb_next_pc_unit;

  logic        clk;
  logic        reset_n;
  logic        stall;
  logic [2:0]  branch_type;
  logic [31:0] branch_off;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        jump;
  logic [25:0] instr_index;
  logic        jr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        taken;
  logic        pending_valid;
  logic        misaligned;

  next_pc_unit dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .branch_type(branch_type),
    .branch_off(branch_off), .rs_data(rs_data), .rt_data(rt_data), .jump(jump),
    .instr_index(instr_index), .jr(jr), .pc(pc), .pc_plus4(pc_plus4),
    .taken(taken), .pending_valid(pending_valid), .misaligned(misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        taken;
    logic        pending_valid;
    logic        misaligned;
  } exp_t;

  exp_t exp_q[$];
  event sample_ev;
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  longint unsigned m_pc;
  bit              m_pv;
  longint unsigned m_pt;

  function automatic bit m_cond(input logic [2:0] bt, input logic [31:0] rs, input logic [31:0] rt);
    int srs;
    srs = int'(rs);
    case (bt)
      3'd1: return rs == rt;
      3'd2: return rs != rt;
      3'd3: return srs <= 0;
      3'd4: return srs > 0;
      3'd5: return srs < 0;
      3'd6: return srs >= 0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic push_expect(input bit tk);
    exp_t e;
    e.pc            = 32'(m_pc);
    e.pc_plus4      = 32'((m_pc + 4) % 64'h1_0000_0000);
    e.taken         = tk;
    e.pending_valid = m_pv;
    e.misaligned    = (m_pc % 4) != 0;
    exp_q.push_back(e);
    -> sample_ev;
  endtask

  task automatic step(input logic st, input logic [2:0] bt, input logic [31:0] off,
                      input logic [31:0] rs, input logic [31:0] rt, input logic j,
                      input logic [25:0] idx, input logic r);
    bit              tk;
    longint unsigned nxt, tgt;
    @(negedge clk);
    reset_n = 1'b1; stall = st; branch_type = bt; branch_off = off;
    rs_data = rs; rt_data = rt; jump = j; instr_index = idx; jr = r;
    #1;
    tk  = r || j || m_cond(bt, rs, rt);
    nxt = (m_pc + 4) % 64'h1_0000_0000;
    if (r)      tgt = rs;
    else if (j) tgt = (nxt / 64'h1000_0000) * 64'h1000_0000 + longint'(idx) * 4;
    else        tgt = (nxt + off) % 64'h1_0000_0000;
    push_expect(tk);
    @(posedge clk);
    if (!st) begin
      if (m_pv) begin m_pc = m_pt; m_pv = 0; end
      else m_pc = tk ? tgt : nxt;
    end else if (!m_pv && tk) begin
      m_pt = tgt; m_pv = 1;
    end
  endtask

  // Assert reset between edges and keep it low across the next rising edge.
  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; stall = 1'b0; branch_type = 3'd0; jump = 1'b0; jr = 1'b0;
    #1;
    m_pc = 64'h3000; m_pv = 0; m_pt = 0;
    push_expect(1'b0);
  endtask

  task automatic idle(); step(1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0, 26'd0, 1'b0); endtask
  task automatic go_jr(input logic [31:0] a); step(1'b0, 3'd0, 32'd0, a, 32'd0, 1'b0, 26'd0, 1'b1); endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(sample_ev);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        cmp("pc", pc, e.pc);
        cmp("pc_plus4", pc_plus4, e.pc_plus4);
        cmp("taken", {31'd0, taken}, {31'd0, e.taken});
        cmp("pending_valid", {31'd0, pending_valid}, {31'd0, e.pending_valid});
        cmp("misaligned", {31'd0, misaligned}, {31'd0, e.misaligned});
      end
    end
  end

  initial begin : driver
    logic [31:0] pool [4];
    reset_n = 1'b0; stall = 1'b0; branch_type = 3'd0; branch_off = 32'd0;
    rs_data = 32'd0; rt_data = 32'd0; jump = 1'b0; instr_index = 26'd0; jr = 1'b0;
    #2;
    do_reset();
    repeat (4) idle();                                              // 3000..300C
    go_jr(32'h3010);
    step(1'b0, 3'd1, 32'hFFFF_FFF0, 32'd5, 32'd5, 1'b0, 26'd0, 1'b0); // beq taken -> 3004
    go_jr(32'h3010);
    step(1'b0, 3'd1, 32'hFFFF_FFF0, 32'd5, 32'd6, 1'b0, 26'd0, 1'b0); // -> 3014
    go_jr(32'h3000);
    step(1'b1, 3'd5, 32'h40, 32'h8000_0000, 32'd0, 1'b0, 26'd0, 1'b0); // bltz
    step(1'b1, 3'd4, 32'h40, 32'd0, 32'd0, 1'b0, 26'd0, 1'b0);         // bgtz 0
    step(1'b1, 3'd3, 32'h40, 32'd0, 32'd0, 1'b0, 26'd0, 1'b0);         // blez 0
    idle();
    go_jr(32'h3000);
    step(1'b0, 3'd0, 32'd0, 32'h4000, 32'd0, 1'b1, 26'h0000100, 1'b1); // jr wins
    go_jr(32'h3000);
    step(1'b0, 3'd0, 32'd0, 32'h4000, 32'd0, 1'b1, 26'h0000100, 1'b0); // -> 0400
    go_jr(32'h3000);
    step(1'b1, 3'd0, 32'd0, 32'd0, 32'd0, 1'b1, 26'h0000100, 1'b0);
    step(1'b1, 3'd1, 32'h0000_00FC, 32'd7, 32'd7, 1'b0, 26'd0, 1'b0);
    step(1'b1, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0, 26'd0, 1'b0);
    idle();                                                         // -> 0400
    idle();
    step(1'b1, 3'd0, 32'd0, 32'd0, 32'd0, 1'b1, 26'h0000100, 1'b0);
    step(1'b1, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0, 26'd0, 1'b0);
    do_reset();                                                     // buffer full
    idle();
    go_jr(32'h0000_3002);
    idle();                                                         // misaligned
    go_jr(32'hFFFF_FFFC);
    idle();                                                         // wraps to 0
    idle();
    pool[0] = 32'd0; pool[1] = 32'd9; pool[2] = 32'h8000_0000; pool[3] = 32'h7FFF_FFFF;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) do_reset();
      step($urandom_range(0, 9) < 3, 3'($urandom_range(0, 7)),
           {{20{1'b0}}, 10'($urandom), 2'b00} - 32'h800,
           ($urandom_range(0, 3) == 0) ? $urandom : pool[$urandom_range(0, 3)],
           pool[$urandom_range(0, 3)],
           $urandom_range(0, 7) == 0, 26'($urandom),
           $urandom_range(0, 7) == 0);
    end
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: timeout reached, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/next_pc_unit.md
# next_pc_unit

Program-counter stage of the single-cycle MIPS datapath. Holds the fetch PC and computes the next PC each cycle: sequential PC+4, a conditional branch target from the word-aligned offset produced by the immediate shifter (shift-by-2 path), a J/JAL target, or a JR target. A one-entry redirect buffer keeps a taken control transfer requested during a stall and applies it when the stall releases.

## Interface
- RESET_PC, 32'h0000_3000, PC value loaded on reset
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- stall  input  1  1 = hold PC this cycle
- branch_type  input  3  000 none, 001 beq, 010 bne, 011 blez, 100 bgtz, 101 bltz, 110 bgez, 111 none
- branch_off  input  32  sign-extended immediate already shifted left by 2
- rs_data  input  32  GPR[rs]; compare operand and JR target
- rt_data  input  32  GPR[rt]; compare operand for beq/bne
- jump  input  1  J/JAL in current instruction
- instr_index  input  26  J-format target field
- jr  input  1  JR/JALR in current instruction
- pc  output  32  current fetch PC (register)
- pc_plus4  output  32  pc + 4, combinational; link value for JAL/JALR
- taken  output  1  combinational; redirect requested this cycle
- pending_valid  output  1  redirect buffer occupied (register)
- misaligned  output  1  combinational; pc[1:0] != 0

## Operation
- Compare (all signed, 32-bit): beq rs==rt; bne rs!=rt; blez rs<=0; bgtz rs>0; bltz rs<0; bgez rs>=0. Codes 000/111 never take.
- Targets: branch = pc_plus4 + branch_off, modulo 2^32 (wrap, no overflow flag); jump = {pc_plus4[31:28], instr_index, 2'b00}; jr = rs_data unmodified.
- Priority when several requested: jr > jump > taken branch. taken = jr | jump | branch condition true.
- Next-state rules, evaluated each rising edge:
  - stall=0, pending_valid=1: pc <= pending target; pending_valid <= 0; current-cycle request ignored.
  - stall=0, pending_valid=0: pc <= selected target if taken, else pc_plus4.
  - stall=1, pending_valid=0, taken=1: pc holds; pending target <= selected target; pending_valid <= 1.
  - stall=1, pending_valid=1: pc and buffer hold; new requests ignored (first request wins).
  - stall=1, taken=0, pending_valid=0: pc holds.
- JR to a non-word-aligned address is loaded as given; misaligned flags it for the exception logic; this block takes no other action.
- pc wraps from 32'hFFFF_FFFC to 32'h0000_0000 on sequential increment.

## Timing
- Reset (async assert, any time including mid-stall with buffer full): pc = RESET_PC, pending_valid = 0, pending target = 0; taken/pc_plus4/misaligned follow combinationally (pc_plus4 = RESET_PC+4, misaligned = 0 for default).
- Reset release is synchronous to the next clk edge in effect: first update occurs on the first rising edge with reset_n high.
- Latency: redirect visible on pc one cycle after request when unstalled; one cycle after stall deasserts when buffered.
- All combinational outputs settle within the cycle; no input is registered except via pc and the buffer.

## Test plan
- Reset, stall=0, no control for 3 edges -> pc = 3000, 3004, 3008, 300C.
- pc=3010, beq with rs=rt=5, branch_off=32'hFFFF_FFF0 -> taken=1, next pc = 3004; same with rt=6 -> next pc = 3014.
- pc=3000, bltz rs=32'h8000_0000 -> taken; bgtz rs=0 -> not taken; blez rs=0 -> taken (signed compare check).
- pc=3000, jump=1, jr=1, rs=32'h0000_4000, instr_index=26'h0000100 -> jr wins, next pc = 4000; jump alone -> next pc = 0000_0400.
- stall=1 for 3 cycles with jump to 0000_0400 in cycle 1 and beq taken to 3100 in cycle 2 -> pc holds, pending_valid=1 from cycle 2; first unstalled edge -> pc = 0000_0400, pending_valid=0.
- Buffer full, assert reset_n=0 between edges -> pc = 3000 and pending_valid = 0 immediately; jr to 0000_3002 -> misaligned=1 next cycle; sequential from FFFF_FFFC -> 0000_0000.
